// File: rtl/incline_sample_ctrl.sv
// Incline sampler: periodically requests a signed 13-bit reading, boxcar-averages
// 2**NSAMP_LOG2 captures and presents the average saturated to signed 10 bits.
module incline_sample_ctrl #(
    parameter int unsigned PERIOD     = 2048,
    parameter int unsigned TIMEOUT    = 64,
    parameter int unsigned NSAMP_LOG2 = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic        inc_req,
    input  logic        inc_vld,
    input  logic [12:0] inc_data,
    output logic [9:0]  incline_sat,
    output logic        sat_vld,
    output logic        sat_flag,
    output logic        timeout_err
);

    localparam int unsigned DATA_W = 13;
    localparam int unsigned OUT_W  = 10;
    localparam int unsigned ACC_W  = DATA_W + NSAMP_LOG2;
    localparam int unsigned PCNT_W = $clog2(PERIOD);
    localparam int unsigned TCNT_W = $clog2(TIMEOUT + 1);
    localparam int unsigned SCNT_W = NSAMP_LOG2 + 1;

    localparam logic [PCNT_W-1:0] PCNT_MAX = PCNT_W'(PERIOD - 1);
    localparam logic [TCNT_W-1:0] TCNT_MAX = TCNT_W'(TIMEOUT - 1);
    localparam logic [SCNT_W-1:0] SCNT_MAX = SCNT_W'((1 << NSAMP_LOG2) - 1);

    localparam logic signed [DATA_W-1:0] AVG_MAX = DATA_W'(511);
    localparam logic signed [DATA_W-1:0] AVG_MIN = -AVG_MAX - DATA_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        UPD  = 2'd2
    } state_t;

    state_t                    state, state_d;
    logic [PCNT_W-1:0]         pcnt;
    logic                      tick;
    logic [TCNT_W-1:0]         tcnt, tcnt_d;
    logic [SCNT_W-1:0]         scnt, scnt_d;
    logic signed [ACC_W-1:0]   acc, acc_d;
    logic signed [ACC_W-1:0]   data_ext;
    logic signed [DATA_W-1:0]  avg;
    logic [OUT_W-1:0]          sat_d;
    logic                      flag_d;
    logic                      vld_d;
    logic                      terr_d;

    assign tick     = en && (pcnt == PCNT_MAX);
    assign data_ext = ACC_W'($signed(inc_data));
    assign avg      = DATA_W'(acc >>> NSAMP_LOG2);

    // Free-running request period, parked at zero while disabled
    always_ff @(posedge clk) begin
        if (rst || !en || tick) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + PCNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        tcnt_d  = tcnt;
        scnt_d  = scnt;
        acc_d   = acc;
        sat_d   = incline_sat;
        flag_d  = sat_flag;
        vld_d   = 1'b0;
        terr_d  = timeout_err;
        case (state)
            IDLE: begin
                tcnt_d = '0;
                if (tick) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                // A reply on the expiry cycle still wins over the timeout
                if (inc_vld) begin
                    acc_d   = acc + data_ext;
                    scnt_d  = scnt + SCNT_W'(1);
                    tcnt_d  = '0;
                    terr_d  = 1'b0;
                    state_d = (scnt == SCNT_MAX) ? UPD : IDLE;
                end else if (tcnt == TCNT_MAX) begin
                    tcnt_d  = '0;
                    terr_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    tcnt_d = tcnt + TCNT_W'(1);
                end
            end
            UPD: begin
                if (avg > AVG_MAX) begin
                    sat_d  = OUT_W'(10'h1FF);
                    flag_d = 1'b1;
                end else if (avg < AVG_MIN) begin
                    sat_d  = OUT_W'(10'h200);
                    flag_d = 1'b1;
                end else begin
                    sat_d  = avg[OUT_W-1:0];
                    flag_d = 1'b0;
                end
                vld_d   = 1'b1;
                acc_d   = '0;
                scnt_d  = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Disable abandons any partial set; an update already in flight completes
        if (!en && state != UPD) begin
            state_d = IDLE;
            tcnt_d  = '0;
            scnt_d  = '0;
            acc_d   = '0;
            terr_d  = timeout_err;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tcnt        <= '0;
            scnt        <= '0;
            acc         <= '0;
            inc_req     <= 1'b0;
            incline_sat <= '0;
            sat_flag    <= 1'b0;
            sat_vld     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            tcnt        <= tcnt_d;
            scnt        <= scnt_d;
            acc         <= acc_d;
            inc_req     <= (state_d == REQ);
            incline_sat <= sat_d;
            sat_flag    <= flag_d;
            sat_vld     <= vld_d;
            timeout_err <= terr_d;
        end
    end

endmodule
